// File: rtl/axis_burst_scheduler.sv
// Round-robin arbiter that shares one AXI-Stream burst master among num_req requesters:
// grants, fires the master's start pulse, tracks the burst to tlast, checks its length, then idles.

module axis_burst_scheduler_chk #(
    parameter int num_req = 4
) (
    input logic               clk,
    input logic               rst,
    input logic [num_req-1:0] gnt,
    input logic [num_req-1:0] done,
    input logic               len_err,
    input logic               busy,
    input logic               en
);

    a_en_single_cycle: assert property (@(posedge clk) disable iff (rst) en |=> !en);

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));

    a_done_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(done));

    a_quiet_when_idle: assert property (@(posedge clk) disable iff (rst)
        !busy |-> ((gnt == '0) && !en));

    a_len_err_with_done: assert property (@(posedge clk) disable iff (rst)
        len_err |-> (done != '0));

endmodule

module axis_burst_scheduler #(
    parameter int num_req     = 4,
    parameter int trans_width = 8,
    parameter int trans_lenth = 2**trans_width,
    parameter int idle_gap    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [num_req-1:0] req,
    output logic [num_req-1:0] gnt,
    output logic [num_req-1:0] done,
    output logic               len_err,
    output logic               busy,
    output logic               en,
    input  logic               m_valid,
    input  logic               m_ready,
    input  logic               m_tlast
);

    localparam int PW       = (num_req > 1) ? $clog2(num_req) : 1;
    localparam int CW       = trans_width + 1;
    localparam int GW       = (idle_gap > 1) ? $clog2(idle_gap + 1) : 1;
    localparam int GAP_LOAD = (idle_gap > 0) ? (idle_gap - 1) : 0;
    localparam logic [CW-1:0] LEN_C = CW'(trans_lenth);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BURST = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t              state_r;
    logic [PW-1:0]       ptr_r;
    logic [CW-1:0]       beat_cnt_r;
    logic [GW-1:0]       gap_cnt_r;

    logic [2*num_req-1:0] rot_s;
    logic                 sel_found_s;
    logic [PW-1:0]        sel_idx_s;
    logic [PW-1:0]        ptr_next_s;
    logic                 beat_s;
    logic [CW-1:0]        beat_inc_s;

    function automatic logic [num_req-1:0] onehot_f(input logic [PW-1:0] idx);
        onehot_f = num_req'(1'b1) << idx;
    endfunction

    // Round-robin search: rotate req so that bit 0 is the requester at ptr_r.
    always_comb begin
        int cand;
        rot_s       = {req, req} >> ptr_r;
        sel_found_s = 1'b0;
        sel_idx_s   = '0;
        cand        = 0;
        for (int i = 0; i < num_req; i++) begin
            if (!sel_found_s && rot_s[i]) begin
                cand = int'(ptr_r) + i;
                if (cand >= num_req) begin
                    cand = cand - num_req;
                end else begin
                    cand = cand;
                end
                sel_found_s = 1'b1;
                sel_idx_s   = PW'(cand);
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    // Pointer advance and saturating beat increment.
    always_comb begin
        if (sel_idx_s == PW'(num_req - 1)) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = sel_idx_s + 1'b1;
        end
        beat_s = m_valid & m_ready;
        if (beat_cnt_r == {CW{1'b1}}) begin
            beat_inc_s = beat_cnt_r;
        end else begin
            beat_inc_s = beat_cnt_r + 1'b1;
        end
    end

    // Scheduler FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            ptr_r      <= '0;
            beat_cnt_r <= '0;
            gap_cnt_r  <= '0;
            gnt        <= '0;
            done       <= '0;
            len_err    <= 1'b0;
            busy       <= 1'b0;
            en         <= 1'b0;
        end else begin
            en      <= 1'b0;
            done    <= '0;
            len_err <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (sel_found_s) begin
                        gnt     <= onehot_f(sel_idx_s);
                        ptr_r   <= ptr_next_s;
                        en      <= 1'b1;
                        busy    <= 1'b1;
                        state_r <= START;
                    end else begin
                        gnt  <= '0;
                        busy <= 1'b0;
                    end
                end
                START: begin
                    beat_cnt_r <= '0;
                    state_r    <= BURST;
                end
                BURST: begin
                    if (beat_s) begin
                        beat_cnt_r <= beat_inc_s;
                        if (m_tlast) begin
                            gnt     <= '0;
                            done    <= gnt;
                            len_err <= (beat_inc_s != LEN_C);
                            if (idle_gap > 0) begin
                                gap_cnt_r <= GW'(GAP_LOAD);
                                busy      <= 1'b1;
                                state_r   <= GAP;
                            end else begin
                                busy    <= 1'b0;
                                state_r <= IDLE;
                            end
                        end else begin
                            state_r <= BURST;
                        end
                    end else begin
                        state_r <= BURST;
                    end
                end
                GAP: begin
                    if (gap_cnt_r == '0) begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r - 1'b1;
                    end
                end
                default: begin
                    gnt     <= '0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    axis_burst_scheduler_chk #(.num_req(num_req)) u_chk (
        .clk     (clk),
        .rst     (rst),
        .gnt     (gnt),
        .done    (done),
        .len_err (len_err),
        .busy    (busy),
        .en      (en)
    );

endmodule
